// File: rtl/msx_clk_pkg.sv
// Shared types and default divisors for the MSX reset sequencer / clock-enable block.
package msx_clk_pkg;

   typedef enum logic [1:0] {
      ST_HOLD     = 2'd0,
      ST_POR_WAIT = 2'd1,
      ST_RUN      = 2'd2,
      ST_SOFT     = 2'd3
   } state_e;

   localparam int DIV_NORMAL_DEF = 6;
   localparam int DIV_TURBO_DEF  = 3;
   localparam int DIV_PSG_DEF    = 2 * DIV_NORMAL_DEF;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int psg_div(input int div_normal);
      return 2 * div_normal;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage synchronizer for a single asynchronous level; output is low while in reset.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   // NOTE: synchronizer flops are reset so a freshly released block never sees a stale "locked".
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/msx_reset_clken.sv
// Reset sequencer (PLL lock / power-on / soft reset) and CPU/PSG clock-enable generator
// for the MSX core running on the 21.484375 MHz master clock.
module msx_reset_clken
   import msx_clk_pkg::*;
#(
   parameter int POR_CYCLES  = 65536,
   parameter int SOFT_CYCLES = 1024,
   parameter int SYNC_STAGES = 2,
   parameter int DIV_NORMAL  = DIV_NORMAL_DEF,
   parameter int DIV_TURBO   = DIV_TURBO_DEF
) (
   input  logic       clock_i,
   input  logic       reset_n_i,
   input  logic       pll_locked_i,
   input  logic       soft_reset_i,
   input  logic       turbo_i,
   output logic       por_o,
   output logic       reset_o,
   output logic       clk_en_cpu_o,
   output logic       clk_en_psg_o,
   output logic [1:0] state_o
);

   localparam int CNT_W  = $clog2(max_int(POR_CYCLES, SOFT_CYCLES));
   localparam int DIV_PSG = psg_div(DIV_NORMAL);
   localparam int CPU_W  = $clog2(max_int(DIV_NORMAL, DIV_TURBO));
   localparam int PSG_W  = $clog2(DIV_PSG);

   localparam logic [CNT_W-1:0] POR_LAST        = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] SOFT_LAST       = CNT_W'(SOFT_CYCLES - 1);
   localparam logic [CPU_W-1:0] CPU_LAST_NORMAL = CPU_W'(DIV_NORMAL - 1);
   localparam logic [CPU_W-1:0] CPU_LAST_TURBO  = CPU_W'(DIV_TURBO - 1);
   localparam logic [PSG_W-1:0] PSG_LAST        = PSG_W'(DIV_PSG - 1);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               r_por;
   logic               r_reset;
   logic               r_soft_q;
   logic               w_soft_rise;
   logic               w_locked_s;

   logic [CPU_W-1:0]   r_cpu_cnt;
   logic [CPU_W-1:0]   w_cpu_last;
   logic               r_turbo;
   logic               r_en_cpu;
   logic [PSG_W-1:0]   r_psg_cnt;
   logic               r_en_psg;
   logic               w_div_hold;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_sync_locked (
      .i_clk   (clock_i),
      .i_rst_n (reset_n_i),
      .i_d     (pll_locked_i),
      .o_q     (w_locked_s)
   );

   assign w_soft_rise = soft_reset_i & ~r_soft_q;
   assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         ST_HOLD: begin
            w_cnt_nxt = '0;
            if (w_locked_s) begin
               w_state_nxt = ST_POR_WAIT;
            end
         end
         ST_POR_WAIT: begin
            if (!w_locked_s) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = '0;
            end else if (r_cnt == POR_LAST) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         ST_RUN: begin
            if (!w_locked_s) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = '0;
            end else if (w_soft_rise) begin
               w_state_nxt = ST_SOFT;
               w_cnt_nxt   = '0;
            end
         end
         ST_SOFT: begin
            // A fresh request restarts the minimum width; a held request just saturates the count.
            if (!w_locked_s) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = '0;
            end else if (w_soft_rise) begin
               w_cnt_nxt = '0;
            end else if ((r_cnt >= SOFT_LAST) && !soft_reset_i) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         default: begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state  <= ST_HOLD;
         r_cnt    <= '0;
         r_por    <= 1'b1;
         r_reset  <= 1'b1;
         r_soft_q <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_por    <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_POR_WAIT);
         r_reset  <= (w_state_nxt != ST_RUN);
         r_soft_q <= soft_reset_i;
      end
   end

   // Dividers sit at 0 for the whole of HOLD, including the edge that enters it,
   // and start counting on the first edge after HOLD is left.
   assign w_div_hold = (r_state == ST_HOLD) || (w_state_nxt == ST_HOLD);
   assign w_cpu_last = r_turbo ? CPU_LAST_TURBO : CPU_LAST_NORMAL;

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_cpu_cnt <= '0;
         r_turbo   <= 1'b0;
         r_en_cpu  <= 1'b0;
      end else if (w_div_hold) begin
         r_cpu_cnt <= '0;
         r_en_cpu  <= 1'b0;
      end else if (r_cpu_cnt == w_cpu_last) begin
         r_cpu_cnt <= '0;
         r_en_cpu  <= 1'b1;
         r_turbo   <= turbo_i;
      end else begin
         r_cpu_cnt <= r_cpu_cnt + 1'b1;
         r_en_cpu  <= 1'b0;
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_psg_cnt <= '0;
         r_en_psg  <= 1'b0;
      end else if (w_div_hold) begin
         r_psg_cnt <= '0;
         r_en_psg  <= 1'b0;
      end else if (r_psg_cnt == PSG_LAST) begin
         r_psg_cnt <= '0;
         r_en_psg  <= 1'b1;
      end else begin
         r_psg_cnt <= r_psg_cnt + 1'b1;
         r_en_psg  <= 1'b0;
      end
   end

   assign por_o        = r_por;
   assign reset_o      = r_reset;
   assign clk_en_cpu_o = r_en_cpu;
   assign clk_en_psg_o = r_en_psg;
   assign state_o      = r_state;

endmodule

// File: tb/tb_msx_reset_clken.sv
// Directed bench for msx_reset_clken with POR_CYCLES=16, SOFT_CYCLES=8; edge_n counts clock
// edges after reset release, and the expected timings below are written against it.
module tb_msx_reset_clken;
   import msx_clk_pkg::*;

   logic       clock_i = 1'b0;
   logic       reset_n_i;
   logic       pll_locked_i;
   logic       soft_reset_i;
   logic       turbo_i;
   logic       por_o;
   logic       reset_o;
   logic       clk_en_cpu_o;
   logic       clk_en_psg_o;
   logic [1:0] state_o;

   int n_pass  = 0;
   int n_total = 0;
   int edge_n  = 0;

   always #5 clock_i = ~clock_i;

   msx_reset_clken #(
      .POR_CYCLES  (16),
      .SOFT_CYCLES (8)
   ) dut (
      .clock_i      (clock_i),
      .reset_n_i    (reset_n_i),
      .pll_locked_i (pll_locked_i),
      .soft_reset_i (soft_reset_i),
      .turbo_i      (turbo_i),
      .por_o        (por_o),
      .reset_o      (reset_o),
      .clk_en_cpu_o (clk_en_cpu_o),
      .clk_en_psg_o (clk_en_psg_o),
      .state_o      (state_o)
   );

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_n, obs, exp);
   endtask

   task automatic check_state(input string tag, input logic [1:0] exp);
      n_total++;
      assert (state_o === exp) n_pass++;
      else $error("FAIL %s @edge %0d: state observed %0d expected %0d", tag, edge_n, state_o, exp);
   endtask

   // Fields packed as {state, por, reset, cpu_en, psg_en}.
   task automatic check_outs(input string tag, input logic [1:0] st, input logic por,
                             input logic rst, input logic cpu, input logic psg);
      logic [5:0] obs;
      logic [5:0] exp;
      obs = {state_o, por_o, reset_o, clk_en_cpu_o, clk_en_psg_o};
      exp = {st, por, rst, cpu, psg};
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s @edge %0d: {st,por,rst,cpu,psg} observed %b expected %b",
                  tag, edge_n, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
      edge_n++;
   endtask

   task automatic tick_to(input int e);
      while (edge_n < e) tick();
   endtask

   initial begin
      reset_n_i    = 1'b0;
      pll_locked_i = 1'b1;
      soft_reset_i = 1'b0;
      turbo_i      = 1'b0;
      repeat (3) @(posedge clock_i);
      #1;
      check_outs("reset_state", ST_HOLD, 1'b1, 1'b1, 1'b0, 1'b0);

      // Power-up: lock synchronized by edge 2, POR_WAIT at 3, RUN at 19.
      reset_n_i = 1'b1;
      edge_n    = 0;
      tick_to(2);
      check_state("hold_edge2", ST_HOLD);
      tick_to(3);
      check_outs("por_wait_edge3", ST_POR_WAIT, 1'b1, 1'b1, 1'b0, 1'b0);
      tick_to(8);
      check_bit("no_cpu_edge8", clk_en_cpu_o, 1'b0);
      tick_to(9);
      check_outs("first_cpu_edge9", ST_POR_WAIT, 1'b1, 1'b1, 1'b1, 1'b0);
      tick_to(18);
      check_outs("por_last_edge18", ST_POR_WAIT, 1'b1, 1'b1, 1'b0, 1'b0);
      tick_to(19);
      check_outs("run_edge19", ST_RUN, 1'b0, 1'b0, 1'b0, 1'b0);

      // Normal rate: CPU at 9+6k, PSG at 15+12k, each PSG pulse paired with a CPU pulse.
      while (edge_n < 46) begin
         tick();
         check_bit("cpu_normal", clk_en_cpu_o, ((edge_n - 9) % 6) == 0);
         check_bit("psg_normal", clk_en_psg_o, ((edge_n - 15) % 12) == 0);
         if (clk_en_psg_o) check_bit("psg_paired", clk_en_cpu_o, 1'b1);
      end

      // Turbo set mid-period: period in flight ends at 51, then every 3 cycles.
      tick_to(47);
      turbo_i = 1'b1;
      while (edge_n < 70) begin
         tick();
         check_bit("cpu_turbo", clk_en_cpu_o,
                   (edge_n == 51) || ((edge_n > 51) && (((edge_n - 51) % 3) == 0)));
         check_bit("psg_turbo", clk_en_psg_o, ((edge_n - 15) % 12) == 0);
      end
      turbo_i = 1'b0;
      while (edge_n < 80) begin
         tick();
         check_bit("cpu_turbo_off", clk_en_cpu_o, (edge_n == 72) || (edge_n == 78));
         check_bit("psg_turbo_off", clk_en_psg_o, edge_n == 75);
      end

      // One-cycle soft reset: reset_o high after edges 81..88.
      soft_reset_i = 1'b1;
      tick_to(81);
      soft_reset_i = 1'b0;
      check_outs("soft_enter", ST_SOFT, 1'b0, 1'b1, 1'b0, 1'b0);
      tick_to(88);
      check_outs("soft_last", ST_SOFT, 1'b0, 1'b1, 1'b0, 1'b0);
      tick_to(89);
      check_outs("soft_exit", ST_RUN, 1'b0, 1'b0, 1'b0, 1'b0);

      // Held soft reset: stays in SOFT until one edge after release; CPU enable keeps running.
      tick_to(90);
      soft_reset_i = 1'b1;
      tick_to(91);
      check_state("soft_held_enter", ST_SOFT);
      tick_to(120);
      check_bit("cpu_in_soft", clk_en_cpu_o, 1'b1);
      check_bit("reset_in_soft", reset_o, 1'b1);
      tick_to(190);
      check_outs("soft_held_end", ST_SOFT, 1'b0, 1'b1, 1'b0, 1'b0);
      soft_reset_i = 1'b0;
      tick_to(191);
      check_outs("soft_held_exit", ST_RUN, 1'b0, 1'b0, 1'b0, 1'b0);

      // Lock loss arriving with a soft reset rise: lock loss wins.
      tick_to(194);
      pll_locked_i = 1'b0;
      tick_to(196);
      check_state("run_before_loss", ST_RUN);
      soft_reset_i = 1'b1;
      tick_to(197);
      check_outs("lockloss_vs_soft", ST_HOLD, 1'b1, 1'b1, 1'b0, 1'b0);
      soft_reset_i = 1'b0;
      tick_to(198);
      check_outs("hold_div_stopped", ST_HOLD, 1'b1, 1'b1, 1'b0, 1'b0);

      // Relock, then lose lock for 3 cycles while cnt=8: full count restarts.
      tick_to(199);
      pll_locked_i = 1'b1;
      tick_to(201);
      check_state("relock_hold", ST_HOLD);
      tick_to(202);
      check_outs("relock_por_wait", ST_POR_WAIT, 1'b1, 1'b1, 1'b0, 1'b0);
      tick_to(208);
      check_bit("relock_cpu", clk_en_cpu_o, 1'b1);
      tick_to(210);
      pll_locked_i = 1'b0;
      tick_to(212);
      check_state("glitch_still_wait", ST_POR_WAIT);
      tick_to(213);
      pll_locked_i = 1'b1;
      check_outs("glitch_hold", ST_HOLD, 1'b1, 1'b1, 1'b0, 1'b0);
      tick_to(214);
      check_outs("glitch_hold_div", ST_HOLD, 1'b1, 1'b1, 1'b0, 1'b0);
      tick_to(216);
      check_state("glitch_rewait", ST_POR_WAIT);
      tick_to(222);
      check_bit("glitch_cpu", clk_en_cpu_o, 1'b1);
      tick_to(231);
      check_outs("glitch_por_last", ST_POR_WAIT, 1'b1, 1'b1, 1'b0, 1'b0);
      tick_to(232);
      check_outs("glitch_run", ST_RUN, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of POR_WAIT, while a CPU pulse is high.
      tick_to(235);
      pll_locked_i = 1'b0;
      tick_to(238);
      check_state("loss_hold", ST_HOLD);
      pll_locked_i = 1'b1;
      tick_to(241);
      check_state("third_wait", ST_POR_WAIT);
      tick_to(247);
      check_outs("pre_async", ST_POR_WAIT, 1'b1, 1'b1, 1'b1, 1'b0);
      reset_n_i = 1'b0;
      #1;
      check_outs("async_reset", ST_HOLD, 1'b1, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
